// File: rtl/rob_commit_sched.sv
// rob_commit_sched: reorder-buffer tag allocation, writeback capture and
// strictly in-order retirement with a flush on a mispredicted branch at the head.
module rob_commit_sched #(
    parameter int ROB_LOG = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               issue_valid,
    input  logic [4:0]         issue_rd,
    input  logic               issue_is_branch,
    output logic               rename_valid,
    output logic [ROB_LOG-1:0] issue_RobId,
    output logic               rob_full,
    input  logic               wb_valid,
    input  logic [ROB_LOG-1:0] wb_RobId,
    input  logic [31:0]        wb_value,
    input  logic               wb_mispredict,
    input  logic [31:0]        wb_target,
    output logic               commit_valid,
    output logic [4:0]         commit_dest,
    output logic [31:0]        commit_value,
    output logic [ROB_LOG-1:0] commit_RobId,
    output logic               jump_flag,
    output logic [31:0]        jump_pc
);
    localparam int DEPTH = 1 << ROB_LOG;
    localparam int CW = ROB_LOG + 1;
    logic [DEPTH-1:0]   r_busy, r_ready, r_isbr, r_mis;
    logic [4:0]         r_dest   [DEPTH];
    logic [31:0]        r_value  [DEPTH];
    logic [31:0]        r_target [DEPTH];
    logic [ROB_LOG-1:0] r_head, r_tail;
    logic [CW-1:0]      r_count;
    logic               r_commit_valid, r_jump;
    logic [4:0]         r_commit_dest;
    logic [31:0]        r_commit_value, r_jump_pc;
    logic [ROB_LOG-1:0] r_commit_id;
    logic               w_wb, w_commit, w_flush;
    assign rob_full     = r_count >= CW'(DEPTH - 1);
    assign rename_valid = issue_valid & ~rob_full & ~r_jump & rdy;
    assign issue_RobId  = r_tail;
    assign w_wb         = wb_valid & ~r_jump & r_busy[wb_RobId];
    // Commit looks only at pre-edge ready, so a same-edge writeback to the head waits one cycle.
    assign w_commit     = ~r_jump & r_busy[r_head] & r_ready[r_head];
    assign w_flush      = w_commit & r_isbr[r_head] & r_mis[r_head];
    assign commit_valid = r_commit_valid;
    assign commit_dest  = r_commit_dest;
    assign commit_value = r_commit_value;
    assign commit_RobId = r_commit_id;
    assign jump_flag    = r_jump;
    assign jump_pc      = r_jump_pc;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy         <= '0;
            r_ready        <= '0;
            r_isbr         <= '0;
            r_mis          <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_dest  <= '0;
            r_commit_value <= '0;
            r_commit_id    <= '0;
            r_jump         <= 1'b0;
            r_jump_pc      <= '0;
        end else if (rdy) begin
            if (w_wb) begin
                r_ready[wb_RobId]  <= 1'b1;
                r_value[wb_RobId]  <= wb_value;
                r_mis[wb_RobId]    <= wb_mispredict;
                r_target[wb_RobId] <= wb_target;
            end
            if (rename_valid) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_dest[r_tail]  <= issue_rd;
                r_isbr[r_tail]  <= issue_is_branch;
                r_tail          <= r_tail + 1'b1;
            end
            r_commit_valid <= w_commit;
            if (w_commit) begin
                r_busy[r_head] <= 1'b0;
                r_head         <= r_head + 1'b1;
                r_commit_dest  <= r_dest[r_head];
                r_commit_value <= r_value[r_head];
                r_commit_id    <= r_head;
            end
            r_count <= r_count + CW'(rename_valid) - CW'(w_commit);
            r_jump  <= w_flush;
            // Flush wins over the allocate/commit pointer updates above.
            if (w_flush) begin
                r_jump_pc <= r_target[r_head];
                r_busy    <= '0;
                r_head    <= '0;
                r_tail    <= '0;
                r_count   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rob_commit_sched.sv
// tb_rob_commit_sched: directed plus randomized stimulus checked against an
// in-order queue model of the reorder buffer.
module tb_rob_commit_sched;
    localparam int LOG = 4;
    localparam int DEPTH = 16;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           rdy = 1'b1;
    logic           issue_valid = 1'b0;
    logic [4:0]     issue_rd = '0;
    logic           issue_is_branch = 1'b0;
    logic           rename_valid;
    logic [LOG-1:0] issue_RobId;
    logic           rob_full;
    logic           wb_valid = 1'b0;
    logic [LOG-1:0] wb_RobId = '0;
    logic [31:0]    wb_value = '0;
    logic           wb_mispredict = 1'b0;
    logic [31:0]    wb_target = '0;
    logic           commit_valid;
    logic [4:0]     commit_dest;
    logic [31:0]    commit_value;
    logic [LOG-1:0] commit_RobId;
    logic           jump_flag;
    logic [31:0]    jump_pc;

    rob_commit_sched #(.ROB_LOG(LOG)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
        .rename_valid(rename_valid), .issue_RobId(issue_RobId), .rob_full(rob_full),
        .wb_valid(wb_valid), .wb_RobId(wb_RobId), .wb_value(wb_value),
        .wb_mispredict(wb_mispredict), .wb_target(wb_target),
        .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_value(commit_value),
        .commit_RobId(commit_RobId), .jump_flag(jump_flag), .jump_pc(jump_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  dest;
        bit          br;
        bit          done;
        logic [31:0] val;
        bit          mis;
        logic [31:0] tgt;
    } ent_t;

    ent_t        rob[$];
    int          head_tag;
    bit          m_cv, m_jf;
    logic [4:0]  m_cd;
    logic [31:0] m_cval, m_jpc;
    int          m_cid;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit exp_full();
        return rob.size() >= DEPTH - 1;
    endfunction

    function automatic bit exp_rv();
        return issue_valid && !exp_full() && !m_jf && rdy;
    endfunction

    task automatic model_reset();
        rob.delete();
        head_tag = 0;
        m_cv = 0; m_cd = '0; m_cval = '0; m_cid = 0; m_jf = 0; m_jpc = '0;
    endtask

    task automatic model_step();
        ent_t e;
        bit c, fl, rv;
        int idx;
        if (rst) begin
            model_reset();
            return;
        end
        if (!rdy) return;
        rv = exp_rv();
        c = !m_jf && rob.size() > 0 && rob[0].done;
        if (c) e = rob[0];
        if (!m_jf && wb_valid) begin
            idx = (int'(wb_RobId) - head_tag + DEPTH) % DEPTH;
            if (idx < rob.size()) begin
                rob[idx].done = 1;
                rob[idx].val  = wb_value;
                rob[idx].mis  = wb_mispredict;
                rob[idx].tgt  = wb_target;
            end
        end
        fl = c && e.br && e.mis;
        m_cv = c;
        if (c) begin
            m_cd = e.dest; m_cval = e.val; m_cid = head_tag;
            rob.delete(0);
            head_tag = (head_tag + 1) % DEPTH;
        end
        m_jf = fl;
        if (fl) begin
            m_jpc = e.tgt;
            rob.delete();
            head_tag = 0;
        end else if (rv) begin
            rob.push_back('{issue_rd, issue_is_branch, 1'b0, 32'h0, 1'b0, 32'h0});
        end
    endtask

    task automatic tick();
        #1;
        check("rename_valid", 32'(rename_valid), 32'(exp_rv()));
        check("issue_RobId", 32'(issue_RobId), 32'((head_tag + rob.size()) % DEPTH));
        check("rob_full", 32'(rob_full), 32'(exp_full()));
        check("commit_valid", 32'(commit_valid), 32'(m_cv));
        check("commit_dest", 32'(commit_dest), 32'(m_cd));
        check("commit_value", commit_value, m_cval);
        check("commit_RobId", 32'(commit_RobId), 32'(m_cid));
        check("jump_flag", 32'(jump_flag), 32'(m_jf));
        check("jump_pc", jump_pc, m_jpc);
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input bit iv, input int rd, input bit br,
                       input bit wv, input int wt, input int wval, input bit wm, input int wtgt);
        issue_valid = iv; issue_rd = rd[4:0]; issue_is_branch = br;
        wb_valid = wv; wb_RobId = wt[LOG-1:0]; wb_value = wval;
        wb_mispredict = wm; wb_target = wtgt;
        tick();
        issue_valid = 0; wb_valid = 0; wb_mispredict = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        @(negedge clk);
        do_reset();
        // in-order commit with out-of-order writeback
        drv(1, 5, 0, 0, 0, 0, 0, 0);
        drv(1, 6, 0, 0, 0, 0, 0, 0);
        drv(1, 7, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 1, 32'h11, 0, 0);
        drv(0, 0, 0, 1, 0, 32'h10, 0, 0);
        drv(0, 0, 0, 1, 2, 32'h12, 0, 0);
        idle(4);
        // fill to full, then wrap the tail
        do_reset();
        for (int i = 0; i < 17; i++) drv(1, i + 1, 0, 0, 0, 0, 0, 0);
        drv(1, 3, 0, 1, 0, 32'hA0, 0, 0);
        idle(1);
        drv(1, 9, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 1, 32'hA1, 0, 0);
        idle(1);
        drv(1, 10, 0, 0, 0, 0, 0, 0);
        drv(1, 11, 0, 0, 0, 0, 0, 0);
        // mispredicted branch at tag 3 with younger entries live
        do_reset();
        for (int i = 0; i < 7; i++) drv(1, i + 1, i == 3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drv(0, 0, 0, 1, i, 32'h100 + i, 0, 0);
        drv(0, 0, 0, 1, 3, 32'h33, 1, 32'h1000);
        idle(3);
        drv(0, 0, 0, 1, 5, 32'h55, 0, 0);
        idle(3);
        // simultaneous allocate and commit at count 8
        do_reset();
        for (int i = 0; i < 8; i++) drv(1, 20, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 0, 32'h77, 0, 0);
        drv(1, 21, 0, 0, 0, 0, 0, 0);
        idle(2);
        // rdy held low while a commit is visible
        do_reset();
        drv(1, 1, 0, 0, 0, 0, 0, 0);
        drv(1, 2, 0, 1, 0, 32'hB0, 0, 0);
        drv(0, 0, 0, 1, 1, 32'hB1, 0, 0);
        rdy = 0;
        drv(1, 4, 0, 0, 0, 0, 0, 0);
        idle(2);
        rdy = 1;
        idle(3);
        // reset with 5 live entries
        for (int i = 0; i < 5; i++) drv(1, i + 3, 0, i == 1, 0, 32'hC0, 0, 0);
        rst = 1;
        drv(1, 9, 0, 1, 1, 32'hC1, 0, 0);
        rst = 0;
        idle(2);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int wbrate, t, sz;
            wbrate = ((i / 200) % 2 == 0) ? 60 : 15;
            rdy = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 499) == 0);
            sz = rob.size();
            t = (sz > 0 && $urandom_range(0, 3) != 0) ?
                (head_tag + int'($urandom_range(0, sz - 1))) % DEPTH : int'($urandom_range(0, DEPTH - 1));
            drv($urandom_range(0, 99) < 70, $urandom_range(0, 31), $urandom_range(0, 3) == 0,
                $urandom_range(0, 99) < wbrate, t, $urandom, $urandom_range(0, 15) == 0, $urandom);
        end
        rst = 0; rdy = 1;
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rob_commit_sched.md
# rob_commit_sched

Reorder-buffer commit scheduler for the out-of-order core. It allocates ROB tags to renamed instructions, collects execution results, and retires entries strictly in program order, one per cycle. Each retirement drives the register file's commit port (`commit_valid/dest/value/RobId`). On a mispredicted branch reaching the head it raises the global `jump_flag`, which flushes rename state everywhere.

## Interface
Parameters:
- `ROB_LOG`, default 4: tag width; depth = 2^ROB_LOG entries.

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — reset, synchronous and active-high.
- `rdy`  in  1  — global enable; low freezes all state and registered outputs.
- `issue_valid`  in  1  — decoder presents an instruction to allocate.
- `issue_rd`  in  5  — destination register (0 = none).
- `issue_is_branch`  in  1  — entry may redirect at commit.
- `rename_valid`  out  1  — allocation accepted this cycle (combinational).
- `issue_RobId`  out  ROB_LOG  — tag given to the instruction (= tail, combinational).
- `rob_full`  out  1  — combinational; `count >= 2^ROB_LOG - 1`.
- `wb_valid`  in  1  — execution result broadcast.
- `wb_RobId`  in  ROB_LOG  — tag being completed.
- `wb_value`  in  32  — result value.
- `wb_mispredict`  in  1  — branch resolved opposite to prediction.
- `wb_target`  in  32  — correct PC if mispredicted.
- `commit_valid`  out  1  — registered; one entry retired.
- `commit_dest`  out  5  — registered.
- `commit_value`  out  32  — registered.
- `commit_RobId`  out  ROB_LOG  — registered.
- `jump_flag`  out  1  — registered; flush pulse.
- `jump_pc`  out  32  — registered redirect PC.

## Operation
- Entry fields: `busy`, `ready`, `dest[4:0]`, `value[31:0]`, `is_branch`, `mispredict`, `target[31:0]`.
- Pointers: `head` and `tail` are ROB_LOG bits wide and wrap naturally. `count` is ROB_LOG+1 bits.
- `rename_valid = issue_valid & ~rob_full & ~jump_flag & rdy`. On the edge, the entry at `tail` is set to busy=1, ready=0, with `dest` and `is_branch` written, and `tail` increments.
- Writeback: when `wb_valid & ~jump_flag`, entry[`wb_RobId`] is set to ready=1 and loaded with value, mispredict and target. A writeback to an entry that is not busy is ignored.
- Commit: evaluated on the pre-edge state. If entry[head] is busy and ready:
  - Clear busy and increment head.
  - Register `commit_valid=1` with dest, value, and `commit_RobId=head`.
  - `commit_valid` is asserted even when dest=0; the register file discards writes to x0.
  - Otherwise `commit_valid<=0`.
- Redirect: if the committing entry has `is_branch & mispredict`:
  - On the same edge, set `jump_flag<=1` and `jump_pc<=target`.
  - Clear every busy bit and set `head=tail=count=0`.
  - `commit_valid` for that branch is still asserted (it covers a JAL/JALR link write).
- While `jump_flag=1`: no allocation, writebacks ignored, no commit. `jump_flag` returns to 0 on the next enabled edge.
- `count` update: +1 on allocate, −1 on commit; a simultaneous allocate and commit leaves it unchanged. A flush overrides both.
- `rdy=0`: nothing changes, and all registered outputs hold their values. This ensures a commit pulse is consumed exactly once by a consumer that is also gated on `rdy`.

## Timing
- Reset values:
  - `commit_valid=0`, `commit_dest=0`, `commit_value=0`, `commit_RobId=0`.
  - `jump_flag=0`, `jump_pc=0`.
  - All entries not busy; head = tail = count = 0.
  - Hence `rob_full=0`, `issue_RobId=0`, `rename_valid=0`.
- Latency:
  - An allocation at edge A lets writeback land at edge ≥ A+1.
  - A writeback at edge W lets the earliest commit edge be W+1.
  - `commit_valid` is high during the cycle after the commit edge.
- Throughput: one allocate, one writeback and one commit per edge.
- `rob_full` reserves one slot; at most 2^ROB_LOG − 1 entries are live.
- Writeback and commit targeting the same entry on one edge: the commit does not see the new ready bit, so that entry commits on the next edge.
- `rst` has priority over everything, including `rdy=0`.

## Test plan
- Reset, then allocate rd=5,6,7 (tags 0,1,2); write back tag 1 (0x11), tag 0 (0x10), tag 2 (0x12) -> commits tag0/rd5/0x10, tag1/rd6/0x11, tag2/rd7/0x12 on consecutive cycles, in order.
- Fill with ROB_LOG=4 -> `rob_full` rises at count=15 and `rename_valid` stays 0. Commit one -> next allocation receives tag 15. A further allocation after wrap receives tag 0.
- Branch at tag 3 with younger tags 4-6 live; writeback tag 3 with mispredict=1 and target 0x1000 -> on commit, `jump_flag=1` and `jump_pc=0x1000` for exactly one cycle. Afterwards count=0 and a writeback to tag 5 produces no commit.
- Allocate and commit on the same edge with count=8 -> count stays 8; head and tail each advance by 1.
- Hold `rdy=0` for 3 cycles while `commit_valid=1` -> outputs unchanged. After `rdy` returns, exactly one commit is observed per entry.
- Assert `rst` in the middle of a sequence with 5 live entries -> the next cycle shows all outputs at their reset values and `issue_RobId=0`.
